// File: rtl/fibonacci_stream.sv
// Streaming Fibonacci-style generator: LANES consecutive terms per beat, modulo 2^W,
// with a programmable term count, valid/ready backpressure and sticky overflow.
module fibonacci_stream #(
  parameter int W     = 16,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W-1:0]       seed_a,
  input  logic [W-1:0]       seed_b,
  input  logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic [LANES-1:0]   out_mask,
  output logic               out_last,
  output logic               done,
  output logic               overflow
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

  state_t             state;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic               ca_reg;
  logic               cb_reg;
  logic [CNT_W-1:0]   remaining_reg;
  logic [LANES-1:0]   out_carry;

  // Chain source: seeds (never carrying) while idle, the stored next pair while running.
  logic [W-1:0]       src_a;
  logic [W-1:0]       src_b;
  logic               src_ca;
  logic               src_cb;
  logic [CNT_W-1:0]   src_rem;

  logic [LANES+1:0][W-1:0] term;
  logic [LANES+1:0]        term_c;
  logic [LANES*W-1:0]      beat_data;
  logic [LANES-1:0]        beat_mask;
  logic [LANES-1:0]        beat_carry;
  logic                    beat_last;

  assign src_a   = (state == IDLE) ? seed_a : a_reg;
  assign src_b   = (state == IDLE) ? seed_b : b_reg;
  assign src_ca  = (state == IDLE) ? 1'b0   : ca_reg;
  assign src_cb  = (state == IDLE) ? 1'b0   : cb_reg;
  assign src_rem = (state == IDLE) ? count  : remaining_reg - LANES_C;

  assign term[0]   = src_a;
  assign term[1]   = src_b;
  assign term_c[0] = src_ca;
  assign term_c[1] = src_cb;

  genvar gi;
  generate
    for (gi = 2; gi < LANES + 2; gi++) begin : g_chain
      assign {term_c[gi], term[gi]} = {1'b0, term[gi-1]} + {1'b0, term[gi-2]};
    end

    // Lanes beyond the remaining count are blanked and cannot raise overflow.
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign beat_mask[gi]          = (src_rem > CNT_W'(gi));
      assign beat_data[gi*W +: W]   = beat_mask[gi] ? term[gi] : '0;
      assign beat_carry[gi]         = beat_mask[gi] & term_c[gi];
    end
  endgenerate

  assign beat_last = (src_rem <= LANES_C);
  assign busy      = (state == RUN);
  assign out_valid = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      ca_reg        <= 1'b0;
      cb_reg        <= 1'b0;
      remaining_reg <= '0;
      out_data      <= '0;
      out_mask      <= '0;
      out_last      <= 1'b0;
      out_carry     <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              state         <= RUN;
              remaining_reg <= count;
              out_data      <= beat_data;
              out_mask      <= beat_mask;
              out_last      <= beat_last;
              out_carry     <= beat_carry;
              a_reg         <= term[LANES];
              b_reg         <= term[LANES+1];
              ca_reg        <= term_c[LANES];
              cb_reg        <= term_c[LANES+1];
            end
          end
        end
        RUN: begin
          if (out_ready) begin
            overflow <= overflow | (|out_carry);
            if (out_last) begin
              state     <= IDLE;
              done      <= 1'b1;
              out_data  <= '0;
              out_mask  <= '0;
              out_last  <= 1'b0;
              out_carry <= '0;
            end else begin
              remaining_reg <= remaining_reg - LANES_C;
              out_data      <= beat_data;
              out_mask      <= beat_mask;
              out_last      <= beat_last;
              out_carry     <= beat_carry;
              a_reg         <= term[LANES];
              b_reg         <= term[LANES+1];
              ca_reg        <= term_c[LANES];
              cb_reg        <= term_c[LANES+1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_stream.sv
// Bench for fibonacci_stream: two instances (W=16/LANES=2 and W=8/LANES=3), a beat
// scoreboard fed by a reference sequence model, a run table and hand-written corner cases.
module tb_fibonacci_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: W=16, LANES=2
  logic        start_a = 0, out_ready_a = 1;
  logic [15:0] seed_a_a = 0, seed_b_a = 0, count_a = 0;
  logic        busy_a, out_valid_a, out_last_a, done_a, overflow_a;
  logic [31:0] out_data_a;
  logic [1:0]  out_mask_a;

  // Instance B: W=8, LANES=3
  logic        start_b = 0, out_ready_b = 1;
  logic [7:0]  seed_a_b = 0, seed_b_b = 0;
  logic [15:0] count_b = 0;
  logic        busy_b, out_valid_b, out_last_b, done_b, overflow_b;
  logic [23:0] out_data_b;
  logic [2:0]  out_mask_b;

  fibonacci_stream #(.W(16), .LANES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .seed_a(seed_a_a), .seed_b(seed_b_a),
    .count(count_a), .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_mask(out_mask_a), .out_last(out_last_a),
    .done(done_a), .overflow(overflow_a));

  fibonacci_stream #(.W(8), .LANES(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .seed_a(seed_a_b), .seed_b(seed_b_b),
    .count(count_b), .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_mask(out_mask_b), .out_last(out_last_b),
    .done(done_b), .overflow(overflow_b));

  typedef struct {
    logic [63:0] data;
    logic [7:0]  mask;
    logic        last;
  } beat_t;

  typedef struct {
    bit     inst;
    int     sa;
    int     sb;
    int     cnt;
    int     nb;
    longint last_data;
    int     last_mask;
    bit     ovf;
  } vec_t;

  beat_t  q_a[$];
  beat_t  q_b[$];
  int     checks = 0;
  int     failures = 0;
  int     nacc_a = 0, nacc_b = 0;
  longint last_d_a = 0, last_d_b = 0;
  int     last_m_a = 0, last_m_b = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: build the beats of a run directly from the term definition.
  function automatic void model(input bit inst, input longint sa, input longint sb, input int cnt);
    int     w   = inst ? 8 : 16;
    int     ln  = inst ? 3 : 2;
    longint md  = longint'(1) << w;
    longint tm1 = 0, tm2 = 0, t = 0;
    int     lane = 0;
    beat_t  b;
    b.data = '0; b.mask = '0; b.last = 1'b0;
    for (int k = 0; k < cnt; k++) begin
      if (k == 0) t = sa;
      else if (k == 1) t = sb;
      else begin
        t = tm1 + tm2;
        if (t >= md) t = t - md;
      end
      tm2 = tm1;
      tm1 = t;
      b.data = b.data | (64'(t) << (lane * w));
      b.mask[lane] = 1'b1;
      lane++;
      if (lane == ln || k == cnt - 1) begin
        b.last = (k == cnt - 1);
        if (inst) q_b.push_back(b); else q_a.push_back(b);
        b.data = '0; b.mask = '0; b.last = 1'b0;
        lane = 0;
      end
    end
  endfunction

  // Scoreboard / hold monitors, sampled on the falling edge.
  logic        stall_a = 0, stall_b = 0;
  logic [31:0] hd_a = 0;
  logic [23:0] hd_b = 0;
  logic [2:0]  hm_a = 0, hm_b = 0;
  logic        hl_a = 0, hl_b = 0;

  always @(negedge clk) begin
    beat_t e;
    if (stall_a) begin
      chk("a_hold_data", out_data_a, hd_a);
      chk("a_hold_mask", out_mask_a, hm_a);
      chk("a_hold_last", out_last_a, hl_a);
    end
    stall_a = out_valid_a && !out_ready_a;
    hd_a = out_data_a; hm_a = 3'(out_mask_a); hl_a = out_last_a;
    if (!rst && out_valid_a && out_ready_a) begin
      if (q_a.size() == 0) begin
        chk("a_beat_unexpected", 1, 0);
      end else begin
        e = q_a.pop_front();
        chk("a_beat_data", out_data_a, e.data);
        chk("a_beat_mask", out_mask_a, e.mask);
        chk("a_beat_last", out_last_a, e.last);
      end
      nacc_a++;
      last_d_a = out_data_a;
      last_m_a = out_mask_a;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (stall_b) begin
      chk("b_hold_data", out_data_b, hd_b);
      chk("b_hold_mask", out_mask_b, hm_b);
      chk("b_hold_last", out_last_b, hl_b);
    end
    stall_b = out_valid_b && !out_ready_b;
    hd_b = out_data_b; hm_b = out_mask_b; hl_b = out_last_b;
    if (!rst && out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) begin
        chk("b_beat_unexpected", 1, 0);
      end else begin
        e = q_b.pop_front();
        chk("b_beat_data", out_data_b, e.data);
        chk("b_beat_mask", out_mask_b, e.mask);
        chk("b_beat_last", out_last_b, e.last);
      end
      nacc_b++;
      last_d_b = out_data_b;
      last_m_b = out_mask_b;
    end
  end

  // One full-throughput run, entered and left just after a rising edge.
  task automatic run(input vec_t v);
    int cycles;
    if (v.inst) begin
      nacc_b = 0; seed_a_b = 8'(v.sa); seed_b_b = 8'(v.sb); count_b = 16'(v.cnt); start_b = 1;
    end else begin
      nacc_a = 0; seed_a_a = 16'(v.sa); seed_b_a = 16'(v.sb); count_a = 16'(v.cnt); start_a = 1;
    end
    model(v.inst, v.sa, v.sb, v.cnt);
    @(posedge clk); #1;
    start_a = 0; start_b = 0;
    @(negedge clk);
    chk("first_valid", v.inst ? out_valid_b : out_valid_a, v.cnt > 0);
    chk("first_busy", v.inst ? busy_b : busy_a, v.cnt > 0);
    cycles = 1;
    while (!(v.inst ? done_b : done_a) && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    chk("done_seen", v.inst ? done_b : done_a, 1);
    chk("done_latency", cycles, v.nb + 1);
    chk("beat_count", v.inst ? nacc_b : nacc_a, v.nb);
    if (v.nb > 0) begin
      chk("last_beat_data", v.inst ? last_d_b : last_d_a, v.last_data);
      chk("last_beat_mask", v.inst ? last_m_b : last_m_a, v.last_mask);
    end
    chk("ovf_at_done", v.inst ? overflow_b : overflow_a, v.ovf);
    chk("busy_after", v.inst ? busy_b : busy_a, 0);
    @(negedge clk);
    chk("done_one_cycle", v.inst ? done_b : done_a, 0);
    chk("ovf_in_idle", v.inst ? overflow_b : overflow_a, v.ovf);
    chk("queue_drained", v.inst ? q_b.size() : q_a.size(), 0);
    $display("run inst=%0d seeds=%0d,%0d count=%0d beats=%0d cycles=%0d ovf=%0d",
             v.inst, v.sa, v.sb, v.cnt, v.inst ? nacc_b : nacc_a, cycles,
             v.inst ? overflow_b : overflow_a);
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];
  bit   pat[6];

  initial begin
    vecs[0] = '{0, 1, 1, 10, 5, (longint'(55) << 16) | 34, 3, 0};
    vecs[1] = '{0, 1, 1, 5, 3, 5, 1, 0};
    vecs[2] = '{0, 1, 1, 25, 13, 9489, 1, 1};
    vecs[3] = '{0, 1, 1, 24, 12, (longint'(46368) << 16) | 28657, 3, 0};
    vecs[4] = '{0, 40000, 30000, 4, 2, (longint'(34464) << 16) | 4464, 3, 1};
    vecs[5] = '{0, 3, 4, 0, 0, 0, 0, 0};
    vecs[6] = '{1, 0, 1, 7, 3, 8, 1, 0};
    vecs[7] = '{1, 200, 100, 3, 1, (longint'(44) << 16) | (longint'(100) << 8) | 200, 7, 1};
    pat = '{1, 0, 0, 1, 0, 1};

    #1 rst = 1;
    #10;
    chk("rst_valid_a", out_valid_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_data_a", out_data_a, 0);
    chk("rst_mask_a", out_mask_a, 0);
    chk("rst_last_a", out_last_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_ovf_a", overflow_a, 0);
    chk("rst_valid_b", out_valid_b, 0);
    chk("rst_data_b", out_data_b, 0);
    chk("rst_ovf_b", overflow_b, 0);
    #10 rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run(vecs[i]);

    // Backpressure with a start pulse that must be ignored mid-run.
    nacc_a = 0;
    seed_a_a = 1; seed_b_a = 1; count_a = 6; start_a = 1;
    model(0, 1, 1, 6);
    @(posedge clk); #1;
    start_a = 0;
    for (int i = 0; i < 6; i++) begin
      out_ready_a = pat[i];
      if (i == 2) begin
        seed_a_a = 7; seed_b_a = 7; count_a = 2; start_a = 1;
      end
      @(posedge clk); #1;
      start_a = 0;
    end
    out_ready_a = 1;
    chk("bp_done", done_a, 1);
    chk("bp_beats", nacc_a, 3);
    chk("bp_last_data", last_d_a, (longint'(8) << 16) | 5);
    chk("bp_ovf", overflow_a, 0);
    chk("bp_queue", q_a.size(), 0);
    $display("run inst=0 backpressure beats=%0d", nacc_a);
    @(posedge clk); #1;
    chk("bp_idle", busy_a, 0);

    // Reset in the middle of an overflowing run.
    seed_a_a = 40000; seed_b_a = 30000; count_a = 20; start_a = 1;
    model(0, 40000, 30000, 20);
    @(posedge clk); #1;
    start_a = 0;
    for (int i = 0; i < 50 && !overflow_a; i++) @(negedge clk);
    chk("ovf_before_rst", overflow_a, 1);
    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("midrst_valid", out_valid_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_ovf", overflow_a, 0);
    chk("midrst_data", out_data_a, 0);
    chk("midrst_mask", out_mask_a, 0);
    $display("midrun reset applied at t=%0t", $time);
    q_a.delete();
    @(posedge clk); #3;
    rst = 0;
    @(posedge clk); #1;
    run(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fibonacci_stream.md
Name: fibonacci_stream

Overview:
- Parametrised successor to the fixed single/double-rate Fibonacci generators: emits LANES consecutive terms of a seeded Fibonacci-style sequence per beat.
- Produces a programmable number of terms, then stops, with valid/ready backpressure, a partial final beat and sticky overflow detection.
- Sits as a stream source feeding downstream checkers/consumers in the sequence-generator family.

Parameters:
W, 16, term width in bits; all arithmetic is modulo 2^W
LANES, 2, terms per output beat (>=1)
CNT_W, 16, width of the term-count input

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a run; sampled only in IDLE
seed_a  input  W  term t0, captured on accepted start
seed_b  input  W  term t1, captured on accepted start
count  input  CNT_W  number of terms to emit, captured on accepted start
busy  output  1  high while a run is in progress (RUN state)
out_valid  output  1  beat available
out_ready  input  1  consumer accepts beat when out_valid && out_ready
out_data  output  LANES*W  lane i at bits [i*W +: W]; lane 0 = earliest term
out_mask  output  LANES  lane-valid bits; all ones except possibly on last beat
out_last  output  1  marks final beat of a run
done  output  1  one-cycle pulse when a run completes
overflow  output  1  sticky: some emitted term's addition carried out of W bits

Behaviour:
- Sequence: t0=seed_a, t1=seed_b, tk=(t(k-1)+t(k-2)) mod 2^W. Beat j lane i carries t(j*LANES+i).
- Reset (async, any time including mid-run): state IDLE; busy=0, out_valid=0, out_data=0, out_mask=0, out_last=0, done=0, overflow=0. Any run in progress is abandoned.
- States:
  - IDLE -> RUN on start with count>0.
  - IDLE -> IDLE with done pulsed the next cycle on start with count==0. No beat is produced.
  - RUN -> IDLE on acceptance of the beat with out_last=1. done=1 in the cycle after that acceptance.
- Run setup: the accepted start captures seeds and count and clears overflow. Remaining-term counter = count.
- Latency: first beat has out_valid=1 in the cycle after start is sampled. out_valid stays 1 throughout RUN.
- Beats are back-to-back. A new beat is presented the cycle after each acceptance, so full throughput is one beat per cycle with out_ready held high.
- Holding rule: while out_valid && !out_ready, out_data, out_mask and out_last are held stable.
- Last beat: out_last=1 when remaining <= LANES.
  - out_mask has the low `remaining` bits set.
  - Masked-off lanes drive 0.
  - Remaining decrements by LANES per accepted beat.
- Arithmetic: an unrolled combinational chain produces LANES terms plus the next (a,b) pair per beat. Registered state is the two next terms plus their carry flags.
- overflow:
  - Set in the cycle after acceptance of a beat in which any unmasked lane's term came from an addition with carry-out of bit W-1.
  - Seeds never set it.
  - Terms that are computed but not emitted never set it.
  - Once set, it stays set until the next accepted start or reset. It remains visible in IDLE after the run ends.
- start during RUN is ignored: no restart, no capture.
- busy = (state==RUN). done and start in the same cycle: start is honoured.
- Terms wrap modulo 2^W and generation continues after overflow.

Test Plan:
- W=16, LANES=2, seeds 1,1, count 10, out_ready=1: beats (1,1),(2,3),(5,8),(13,21),(34,55) on consecutive cycles. out_last on 5th beat, mask 11 on all beats, done pulses 1 cycle after 5th acceptance, overflow=0.
- Same config, count 5: beats (1,1),(2,3),(5,0). Last beat mask 01 with lane1=0.
- Overflow: seeds 1,1, count 25: 13 beats, last beat lane0=9489 (75025 mod 65536), mask 01, overflow=1 after it, still 1 in IDLE. Count 24 instead: overflow stays 0, last beat (28657,46368).
- Backpressure: count 6, out_ready toggling 1,0,0,1,0,1: data held stable while stalled. Exactly 3 accepted beats (1,1),(2,3),(5,8). start pulsed mid-run is ignored.
- Edge cases: count 0 gives no out_valid and done pulses 1 cycle after start. rst asserted mid-run (between clocks) immediately drops out_valid/busy/overflow. A new start afterwards produces a clean sequence.
- LANES=3, W=8, seeds 0,1, count 7: beats (0,1,1),(2,3,5),(8,0,0) with last mask 001. Seeds 200,100, count 3: beat (200,100,44), overflow=1.
